// File: rtl/net_combine_pipe.sv
// Registered N-channel bitwise combiner feeding a 2-entry valid/ready output buffer.
// Optional per-entry parity output when NET_COMBINE_PARITY_EN is defined.
module net_combine_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
`ifdef NET_COMBINE_PARITY_EN
  output logic                      out_parity,
`endif
  output logic [CNT_W-1:0]          beat_count
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] result;
  logic             accept, deliver;

  always_comb begin
    result = in_data[WIDTH-1:0];
    for (int k = 1; k < CHANNELS; k++) begin
      case (in_mode)
        2'b00:   result = result & in_data[k*WIDTH +: WIDTH];
        2'b01:   result = result | in_data[k*WIDTH +: WIDTH];
        2'b10:   result = result ^ in_data[k*WIDTH +: WIDTH];
        default: result = result;
      endcase
    end
  end

  // in_ready is a function of registered occupancy only (plus reset), never out_ready.
  assign in_ready  = (occ_q != 2'd2) && !rst;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = data0_q;
  assign beat_count = count_q;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // Entry 0 is always the head; entry 1 only ever holds the second-oldest beat.
  always_comb begin
    occ_d   = occ_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (accept && deliver) begin
      data0_d = result;
    end else if (accept) begin
      if (occ_q == 2'd0) data0_d = result;
      else               data1_d = result;
      occ_d = occ_q + 2'd1;
    end else if (deliver) begin
      data0_d = data1_q;
      occ_d   = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      if (deliver) count_q <= count_q + 1'b1;
    end
  end

`ifdef NET_COMBINE_PARITY_EN
  logic par0_q, par0_d, par1_q, par1_d;

  always_comb begin
    par0_d = par0_q;
    par1_d = par1_q;
    if (accept && deliver) begin
      par0_d = ^result;
    end else if (accept) begin
      if (occ_q == 2'd0) par0_d = ^result;
      else               par1_d = ^result;
    end else if (deliver) begin
      par0_d = par1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par0_q <= 1'b0;
      par1_q <= 1'b0;
    end else begin
      par0_q <= par0_d;
      par1_q <= par1_d;
    end
  end

  assign out_parity = par0_q;
`endif

endmodule

// File: tb/tb_net_combine_pipe.sv
// Self-checking bench for net_combine_pipe: queue-based reference model plus directed literals.
module tb_net_combine_pipe;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned CNT_W    = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [1:0]                in_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [CNT_W-1:0]          beat_count;
`ifdef NET_COMBINE_PARITY_EN
  logic                      out_parity;
`endif

  net_combine_pipe #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef NET_COMBINE_PARITY_EN
    .out_parity(out_parity),
`endif
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [WIDTH-1:0] q[$];
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference operator: reduce the channel words with the chosen bitwise operator.
  function automatic logic [WIDTH-1:0] ref_comb(input logic [CHANNELS*WIDTH-1:0] d,
                                                 input logic [1:0] m);
    logic [WIDTH-1:0] w[CHANNELS];
    logic [WIDTH-1:0] r;
    for (int k = 0; k < CHANNELS; k++) w[k] = d[k*WIDTH +: WIDTH];
    r = w[0];
    if (m == 2'b00)      for (int k = 1; k < CHANNELS; k++) r = r & w[k];
    else if (m == 2'b01) for (int k = 1; k < CHANNELS; k++) r = r | w[k];
    else if (m == 2'b10) for (int k = 1; k < CHANNELS; k++) r = r ^ w[k];
    return r;
  endfunction

  // Model: a FIFO of at most two results, updated on every rising edge.
  initial begin
    bit acc, del;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_cnt = '0;
      end else begin
        acc = in_valid && (q.size() < 2);
        del = out_ready && (q.size() > 0);
        if (del) begin
          void'(q.pop_front());
          m_cnt = m_cnt + 1'b1;
        end
        if (acc) q.push_back(ref_comb(in_data, in_mode));
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", 32'(in_ready), 32'(!rst && (q.size() < 2)));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
          chk("out_data", 32'(out_data), 32'(q[0]));
`ifdef NET_COMBINE_PARITY_EN
          chk("out_parity", 32'(out_parity), 32'(^q[0]));
`endif
        end
        chk("beat_count", 32'(beat_count), 32'(m_cnt));
      end
    end
  end

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] m,
                      input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 16'h0, 2'b00, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Operators with ch0=F0, ch1=3C
    step(1'b1, 16'h3CF0, 2'b00, 1'b1); chk("op_and", 32'(out_data), 32'h30);
    step(1'b1, 16'h3CF0, 2'b01, 1'b1); chk("op_or", 32'(out_data), 32'hFC);
    step(1'b1, 16'h3CF0, 2'b10, 1'b1); chk("op_xor", 32'(out_data), 32'hCC);
    step(1'b1, 16'h3CF0, 2'b11, 1'b1); chk("op_pass", 32'(out_data), 32'hF0);
    step(1'b0, 16'h0, 2'b00, 1'b1);
    chk("op_count", 32'(beat_count), 32'd4);

    // Backpressure
    step(1'b1, 16'h0011, 2'b11, 1'b0);
    step(1'b1, 16'h0022, 2'b11, 1'b0);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'h0033, 2'b11, 1'b0);
    chk("bp_hold_data", 32'(out_data), 32'h11);
    chk("bp_hold_count", 32'(beat_count), 32'd4);
    step(1'b0, 16'h0, 2'b00, 1'b1);
    chk("bp_second", 32'(out_data), 32'h22);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step(1'b0, 16'h0, 2'b00, 1'b1);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(beat_count), 32'd6);

    // Streaming 100 beats in 101 cycles; count wraps at 16
    for (int i = 0; i < 100; i++) begin
      logic [7:0] b;
      b = 8'(i);
      step(1'b1, {b ^ 8'h5A, b}, 2'(i % 4), 1'b1);
    end
    step(1'b0, 16'h0, 2'b00, 1'b1);
    chk("stream_count", 32'(beat_count), 32'd10);

    // Wrap after reset: 17 deliveries -> 1
    rst = 1'b1;
    step(1'b0, 16'h0, 2'b00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) step(1'b1, 16'h0F0F, 2'b01, 1'b1);
    step(1'b0, 16'h0, 2'b00, 1'b1);
    chk("wrap_count", 32'(beat_count), 32'd1);

    // Reset while full discards both entries
    step(1'b1, 16'h00AA, 2'b11, 1'b0);
    step(1'b1, 16'h00BB, 2'b11, 1'b0);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step(1'b0, 16'h0, 2'b00, 1'b0);
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(beat_count), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 2'b00, 1'b1);
    chk("midrst_no_stale", 32'(out_valid), 32'd0);

    // Parity vectors
    step(1'b1, 16'h3CF0, 2'b00, 1'b0);
    chk("par_data_30", 32'(out_data), 32'h30);
`ifdef NET_COMBINE_PARITY_EN
    chk("par_30", 32'(out_parity), 32'd0);
`endif
    step(1'b1, 16'h00F1, 2'b11, 1'b1);
    step(1'b0, 16'h0, 2'b00, 1'b0);
    chk("par_data_f1", 32'(out_data), 32'hF1);
`ifdef NET_COMBINE_PARITY_EN
    chk("par_f1", 32'(out_parity), 32'd1);
`endif
    step(1'b0, 16'h0, 2'b00, 1'b1);
    step(1'b0, 16'h0, 2'b00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
